// File: rtl/sdram_pkg.sv
// Shared SDRAM command encodings, bus widths and arbiter state type.
package sdram_pkg;

    localparam int unsigned ADDR_W = 12;
    localparam int unsigned BANK_W = 2;
    localparam int unsigned CMD_W  = 4;
    localparam int unsigned WD_W   = 10;

    // {cs_n, ras_n, cas_n, we_n}
    localparam logic [CMD_W-1:0] CMD_NOP  = 4'b0111;
    localparam logic [CMD_W-1:0] CMD_PRE  = 4'b0010;
    localparam logic [CMD_W-1:0] CMD_AREF = 4'b0001;
    localparam logic [CMD_W-1:0] CMD_ACT  = 4'b0011;
    localparam logic [CMD_W-1:0] CMD_WR   = 4'b0100;
    localparam logic [CMD_W-1:0] CMD_RD   = 4'b0101;
    localparam logic [CMD_W-1:0] CMD_MRS  = 4'b0000;

    typedef enum logic [2:0] {
        ST_INIT  = 3'd0,
        ST_ARBIT = 3'd1,
        ST_AREF  = 3'd2,
        ST_WRITE = 3'd3,
        ST_READ  = 3'd4
    } arb_state_e;

endpackage

// File: rtl/sdram_arbit.sv
// SDRAM bus arbiter: init -> arbitration between refresh, write and read
// clients, with per-phase watchdog and a state-driven command/address mux.
module sdram_arbit
    import sdram_pkg::*;
#(
    parameter logic [CMD_W-1:0] NOP     = 4'b0111,
    parameter logic [WD_W-1:0]  TMO_END = 10'd1000
) (
    input  logic              sclk,
    input  logic              s_rst_n,
    input  logic              flag_init_end,
    input  logic [CMD_W-1:0]  init_cmd,
    input  logic [ADDR_W-1:0] init_addr,
    input  logic              ref_req,
    input  logic              flag_ref_end,
    input  logic [CMD_W-1:0]  ref_cmd,
    input  logic [ADDR_W-1:0] ref_addr,
    input  logic [BANK_W-1:0] ref_bank,
    input  logic              wr_req,
    input  logic              flag_wr_end,
    input  logic [CMD_W-1:0]  wr_cmd,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [BANK_W-1:0] wr_bank,
    input  logic              rd_req,
    input  logic              flag_rd_end,
    input  logic [CMD_W-1:0]  rd_cmd,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic [BANK_W-1:0] rd_bank,
    output logic              ref_en,
    output logic              wr_en,
    output logic              rd_en,
    output logic              ref_pending,
    output logic [CMD_W-1:0]  sdram_cmd,
    output logic [ADDR_W-1:0] sdram_addr,
    output logic [BANK_W-1:0] sdram_bank,
    output logic              tmo_err
);

    arb_state_e        state_q, state_d;
    logic              last_rd_q, last_rd_d;   // 1: read was the last write/read grant
    logic [WD_W-1:0]   wd_q, wd_d;
    logic              ref_en_q, ref_en_d;
    logic              wr_en_q, wr_en_d;
    logic              rd_en_q, rd_en_d;
    logic              ref_pending_q, ref_pending_d;
    logic              tmo_err_q, tmo_err_d;
    logic              owned_c;
    logic              end_c;

    // Next-state, grant and watchdog decisions
    always_comb begin
        state_d       = state_q;
        last_rd_d     = last_rd_q;
        ref_en_d      = 1'b0;
        wr_en_d       = 1'b0;
        rd_en_d       = 1'b0;
        tmo_err_d     = 1'b0;
        end_c         = 1'b0;
        owned_c       = 1'b0;
        ref_pending_d = ref_req && (state_q == ST_WRITE || state_q == ST_READ);

        case (state_q)
            ST_INIT: begin
                if (flag_init_end) state_d = ST_ARBIT;
            end
            ST_ARBIT: begin
                if (ref_req) begin
                    state_d  = ST_AREF;
                    ref_en_d = 1'b1;
                end else if (wr_req && (!rd_req || last_rd_q)) begin
                    state_d   = ST_WRITE;
                    wr_en_d   = 1'b1;
                    last_rd_d = 1'b0;
                end else if (rd_req) begin
                    state_d   = ST_READ;
                    rd_en_d   = 1'b1;
                    last_rd_d = 1'b1;
                end
            end
            ST_AREF: begin
                owned_c = 1'b1;
                end_c   = flag_ref_end;
            end
            ST_WRITE: begin
                owned_c = 1'b1;
                end_c   = flag_wr_end;
            end
            ST_READ: begin
                owned_c = 1'b1;
                end_c   = flag_rd_end;
            end
            default: state_d = ST_INIT;
        endcase

        // A normal end takes precedence over a coincident watchdog expiry
        if (owned_c) begin
            if (end_c) begin
                state_d = ST_ARBIT;
            end else if (wd_q == TMO_END - WD_W'(1)) begin
                state_d   = ST_ARBIT;
                tmo_err_d = 1'b1;
            end
        end

        wd_d = (state_d != state_q || !owned_c) ? '0 : wd_q + WD_W'(1);
    end

    // State, watchdog and registered outputs
    always_ff @(posedge sclk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            state_q       <= ST_INIT;
            last_rd_q     <= 1'b1;
            wd_q          <= '0;
            ref_en_q      <= 1'b0;
            wr_en_q       <= 1'b0;
            rd_en_q       <= 1'b0;
            ref_pending_q <= 1'b0;
            tmo_err_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            last_rd_q     <= last_rd_d;
            wd_q          <= wd_d;
            ref_en_q      <= ref_en_d;
            wr_en_q       <= wr_en_d;
            rd_en_q       <= rd_en_d;
            ref_pending_q <= ref_pending_d;
            tmo_err_q     <= tmo_err_d;
        end
    end

    // SDRAM bus mux follows the owner; idle during reset and arbitration
    always_comb begin
        sdram_cmd  = NOP;
        sdram_addr = '0;
        sdram_bank = '0;
        if (s_rst_n) begin
            case (state_q)
                ST_INIT: begin
                    sdram_cmd  = init_cmd;
                    sdram_addr = init_addr;
                end
                ST_AREF: begin
                    sdram_cmd  = ref_cmd;
                    sdram_addr = ref_addr;
                    sdram_bank = ref_bank;
                end
                ST_WRITE: begin
                    sdram_cmd  = wr_cmd;
                    sdram_addr = wr_addr;
                    sdram_bank = wr_bank;
                end
                ST_READ: begin
                    sdram_cmd  = rd_cmd;
                    sdram_addr = rd_addr;
                    sdram_bank = rd_bank;
                end
                default: ;
            endcase
        end
    end

    assign ref_en      = ref_en_q;
    assign wr_en       = wr_en_q;
    assign rd_en       = rd_en_q;
    assign ref_pending = ref_pending_q;
    assign tmo_err     = tmo_err_q;

endmodule

// File: tb/tb_sdram_arbit.sv
// Self-checking bench for sdram_arbit: directed tables and sequences plus
// a randomized run against a behavioural ownership model.
`timescale 1ns/1ps
module tb_sdram_arbit;
    import sdram_pkg::*;

    localparam logic [3:0] NOPC = 4'b0111;
    localparam int TMO = 1000;
    localparam int O_INIT = 0, O_ARB = 1, O_REF = 2, O_WR = 3, O_RD = 4;

    logic        sclk = 1'b0;
    logic        s_rst_n = 1'b0;
    logic        flag_init_end = 1'b0;
    logic [3:0]  init_cmd = 4'h2;
    logic [11:0] init_addr = 12'hA5A;
    logic        ref_req = 1'b0, flag_ref_end = 1'b0;
    logic [3:0]  ref_cmd = 4'h1;
    logic [11:0] ref_addr = 12'h400;
    logic [1:0]  ref_bank = 2'd1;
    logic        wr_req = 1'b0, flag_wr_end = 1'b0;
    logic [3:0]  wr_cmd = 4'h4;
    logic [11:0] wr_addr = 12'h123;
    logic [1:0]  wr_bank = 2'd2;
    logic        rd_req = 1'b0, flag_rd_end = 1'b0;
    logic [3:0]  rd_cmd = 4'h5;
    logic [11:0] rd_addr = 12'h456;
    logic [1:0]  rd_bank = 2'd3;
    logic        ref_en, wr_en, rd_en, ref_pending, tmo_err;
    logic [3:0]  sdram_cmd;
    logic [11:0] sdram_addr;
    logic [1:0]  sdram_bank;
    logic [2:0]  ens;

    int checks = 0;
    int failures = 0;

    // model state
    int         m_own;
    int         m_age;
    logic       m_wr_turn;
    logic [2:0] x_en;
    logic       x_pend, x_tmo;

    typedef struct packed {
        logic [2:0] req;      // {ref, wr, rd}
        logic [2:0] exp_en;   // {ref_en, wr_en, rd_en}
        logic [3:0] exp_cmd;
    } vec_t;
    vec_t tv [8];

    sdram_arbit dut (
        .sclk(sclk), .s_rst_n(s_rst_n), .flag_init_end(flag_init_end),
        .init_cmd(init_cmd), .init_addr(init_addr),
        .ref_req(ref_req), .flag_ref_end(flag_ref_end),
        .ref_cmd(ref_cmd), .ref_addr(ref_addr), .ref_bank(ref_bank),
        .wr_req(wr_req), .flag_wr_end(flag_wr_end),
        .wr_cmd(wr_cmd), .wr_addr(wr_addr), .wr_bank(wr_bank),
        .rd_req(rd_req), .flag_rd_end(flag_rd_end),
        .rd_cmd(rd_cmd), .rd_addr(rd_addr), .rd_bank(rd_bank),
        .ref_en(ref_en), .wr_en(wr_en), .rd_en(rd_en), .ref_pending(ref_pending),
        .sdram_cmd(sdram_cmd), .sdram_addr(sdram_addr), .sdram_bank(sdram_bank),
        .tmo_err(tmo_err)
    );

    assign ens = {ref_en, wr_en, rd_en};

    always #5 sclk = ~sclk;

    task automatic tick();
        @(posedge sclk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected bus for a given owner, from the current client inputs
    function automatic logic [17:0] exp_bus(input int own);
        case (own)
            O_INIT:  return {init_cmd, init_addr, 2'b00};
            O_REF:   return {ref_cmd, ref_addr, ref_bank};
            O_WR:    return {wr_cmd, wr_addr, wr_bank};
            O_RD:    return {rd_cmd, rd_addr, rd_bank};
            default: return {NOPC, 12'h000, 2'b00};
        endcase
    endfunction

    // One clock of the ownership model, using the inputs seen before the edge
    task automatic model_step();
        logic done;
        x_en   = 3'b000;
        x_tmo  = 1'b0;
        x_pend = ref_req && (m_own == O_WR || m_own == O_RD);
        case (m_own)
            O_INIT: if (flag_init_end) m_own = O_ARB;
            O_ARB: begin
                m_age = 0;
                if (ref_req) begin
                    m_own = O_REF; x_en = 3'b100;
                end else if (wr_req && (!rd_req || m_wr_turn)) begin
                    m_own = O_WR; x_en = 3'b010; m_wr_turn = 1'b0;
                end else if (rd_req) begin
                    m_own = O_RD; x_en = 3'b001; m_wr_turn = 1'b1;
                end
            end
            default: begin
                done = (m_own == O_REF) ? flag_ref_end :
                       (m_own == O_WR)  ? flag_wr_end  : flag_rd_end;
                if (done) begin
                    m_own = O_ARB;
                end else if (m_age + 1 == TMO) begin
                    m_own = O_ARB; x_tmo = 1'b1;
                end else begin
                    m_age++;
                end
            end
        endcase
    endtask

    task automatic clear_inputs();
        {ref_req, wr_req, rd_req} = 3'b000;
        {flag_init_end, flag_ref_end, flag_wr_end, flag_rd_end} = 4'b0000;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        int bad;
        int n;
        logic [2:0] cur;
        logic [2:0] nxt;

        tv[0] = '{req: 3'b111, exp_en: 3'b100, exp_cmd: 4'h1};
        tv[1] = '{req: 3'b011, exp_en: 3'b010, exp_cmd: 4'h4};
        tv[2] = '{req: 3'b011, exp_en: 3'b001, exp_cmd: 4'h5};
        tv[3] = '{req: 3'b001, exp_en: 3'b001, exp_cmd: 4'h5};
        tv[4] = '{req: 3'b011, exp_en: 3'b010, exp_cmd: 4'h4};
        tv[5] = '{req: 3'b010, exp_en: 3'b010, exp_cmd: 4'h4};
        tv[6] = '{req: 3'b011, exp_en: 3'b001, exp_cmd: 4'h5};
        tv[7] = '{req: 3'b000, exp_en: 3'b000, exp_cmd: NOPC};

        // Reset and init phase
        #12;
        chk("rst_cmd", 32'({sdram_cmd, sdram_addr, sdram_bank}), 32'({NOPC, 12'h0, 2'b0}));
        chk("rst_outs", 32'({ens, ref_pending, tmo_err}), 32'd0);
        @(posedge sclk); #1;
        s_rst_n = 1'b1;
        #1;
        chk("init_bus", 32'({sdram_cmd, sdram_addr, sdram_bank}), 32'({init_cmd, init_addr, 2'b0}));
        bad = 0;
        ref_req = 1'b1; wr_req = 1'b1;
        repeat (200) begin
            tick();
            if (ens != 3'b000 || sdram_cmd != init_cmd) bad++;
        end
        ref_req = 1'b0; wr_req = 1'b0;
        chk("init_hold", 32'(bad), 32'd0);
        flag_init_end = 1'b1; tick(); flag_init_end = 1'b0;
        chk("init_exit", 32'({ens, sdram_cmd, sdram_addr, sdram_bank}), 32'({3'b0, NOPC, 12'h0, 2'b0}));

        // Arbitration table; each grant is ended by its own flag after foreign flags are ignored
        for (int i = 0; i < 8; i++) begin
            {ref_req, wr_req, rd_req} = tv[i].req;
            tick();
            {ref_req, wr_req, rd_req} = 3'b000;
            chk($sformatf("tv%0d_en", i), 32'(ens), 32'(tv[i].exp_en));
            chk($sformatf("tv%0d_cmd", i), 32'(sdram_cmd), 32'(tv[i].exp_cmd));
            if (tv[i].exp_en != 3'b000) begin
                {flag_ref_end, flag_wr_end, flag_rd_end} = ~tv[i].exp_en;
                flag_init_end = 1'b1;
                tick();
                chk($sformatf("tv%0d_foreign_end", i), 32'({ens, sdram_cmd}), 32'({3'b000, tv[i].exp_cmd}));
                flag_init_end = 1'b0;
                {flag_ref_end, flag_wr_end, flag_rd_end} = tv[i].exp_en;
                {ref_req, wr_req, rd_req} = 3'b111;
                tick();
                clear_inputs();
                chk($sformatf("tv%0d_end_arbit", i), 32'({ens, sdram_cmd}), 32'({3'b000, NOPC}));
                tick();
            end
        end

        // Refresh beats pending write/read, then write wins after a read was last
        {ref_req, wr_req, rd_req} = 3'b111;
        tick();
        ref_req = 1'b0;
        chk("ref_grant", 32'({ens, sdram_cmd}), 32'({3'b100, ref_cmd}));
        bad = 0;
        repeat (10) begin
            tick();
            if (ens != 3'b000 || sdram_cmd != ref_cmd) bad++;
        end
        chk("ref_hold", 32'(bad), 32'd0);
        flag_ref_end = 1'b1; tick(); flag_ref_end = 1'b0;
        chk("ref_end", 32'({ens, sdram_cmd}), 32'({3'b000, NOPC}));
        tick();
        chk("post_ref_wr", 32'({ens, sdram_cmd}), 32'({3'b010, wr_cmd}));

        // Both held: grants alternate
        cur = 3'b010;
        for (int g = 0; g < 4; g++) begin
            repeat (5) tick();
            {flag_ref_end, flag_wr_end, flag_rd_end} = cur;
            tick();
            {flag_ref_end, flag_wr_end, flag_rd_end} = 3'b000;
            chk($sformatf("alt%0d_arbit", g), 32'({ens, sdram_cmd}), 32'({3'b000, NOPC}));
            tick();
            nxt = (cur == 3'b010) ? 3'b001 : 3'b010;
            chk($sformatf("alt%0d_grant", g), 32'(ens), 32'(nxt));
            cur = nxt;
        end
        wr_req = 1'b0; rd_req = 1'b0;
        flag_wr_end = 1'b1; tick(); flag_wr_end = 1'b0;
        chk("alt_done", 32'(sdram_cmd), 32'(NOPC));

        // Refresh pending during a write
        wr_req = 1'b1; tick(); wr_req = 1'b0;
        chk("pend_wr_grant", 32'(ens), 32'(3'b010));
        ref_req = 1'b1; tick();
        chk("pend_set", 32'({ref_pending, sdram_cmd}), 32'({1'b1, wr_cmd}));
        flag_wr_end = 1'b1; tick(); flag_wr_end = 1'b0;
        chk("pend_end", 32'({ens, ref_pending, sdram_cmd}), 32'({3'b000, 1'b1, NOPC}));
        tick();
        chk("pend_ref_grant", 32'({ens, ref_pending}), 32'({3'b100, 1'b0}));
        ref_req = 1'b0;
        flag_ref_end = 1'b1; tick(); flag_ref_end = 1'b0;
        chk("pend_ref_done", 32'(sdram_cmd), 32'(NOPC));

        // Watchdog expiry on an abandoned write
        wr_req = 1'b1; tick(); wr_req = 1'b0;
        chk("tmo_grant", 32'(ens), 32'(3'b010));
        n = 0;
        while (n < 1100) begin
            tick();
            n++;
            if (tmo_err) break;
        end
        chk("tmo_latency", 32'(n), 32'(TMO));
        chk("tmo_bus", 32'({ens, sdram_cmd}), 32'({3'b000, NOPC}));
        tick();
        chk("tmo_pulse_once", 32'({tmo_err, sdram_cmd}), 32'({1'b0, NOPC}));

        // End flag coinciding with expiry is a normal end
        wr_req = 1'b1; tick(); wr_req = 1'b0;
        repeat (TMO - 1) tick();
        chk("tmo_edge_owned", 32'({tmo_err, sdram_cmd}), 32'({1'b0, wr_cmd}));
        flag_wr_end = 1'b1; tick(); flag_wr_end = 1'b0;
        chk("tmo_vs_end", 32'({tmo_err, sdram_cmd}), 32'({1'b0, NOPC}));

        // Randomized run against the ownership model
        clear_inputs();
        s_rst_n = 1'b0; tick(); s_rst_n = 1'b1;
        m_own = O_INIT; m_age = 0; m_wr_turn = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            ref_req       = ($urandom_range(0, 5) == 0);
            wr_req        = ($urandom_range(0, 2) == 0);
            rd_req        = ($urandom_range(0, 2) == 0);
            flag_init_end = ($urandom_range(0, 7) == 0);
            flag_ref_end  = ($urandom_range(0, 4) == 0);
            flag_wr_end   = ($urandom_range(0, 4) == 0);
            flag_rd_end   = ($urandom_range(0, 4) == 0);
            init_cmd = 4'($urandom); init_addr = 12'($urandom);
            ref_cmd  = 4'($urandom); ref_addr  = 12'($urandom); ref_bank = 2'($urandom);
            wr_cmd   = 4'($urandom); wr_addr   = 12'($urandom); wr_bank  = 2'($urandom);
            rd_cmd   = 4'($urandom); rd_addr   = 12'($urandom); rd_bank  = 2'($urandom);
            model_step();
            tick();
            chk($sformatf("rand%0d", c),
                32'({ens, ref_pending, tmo_err, sdram_cmd, sdram_addr, sdram_bank}),
                32'({x_en, x_pend, x_tmo, exp_bus(m_own)}));
        end

        // Reset in the middle of a read
        clear_inputs();
        init_cmd = 4'h2; init_addr = 12'hA5A;
        rd_cmd = 4'h5; rd_addr = 12'h456; rd_bank = 2'd3;
        s_rst_n = 1'b0; tick(); s_rst_n = 1'b1;
        flag_init_end = 1'b1; tick(); flag_init_end = 1'b0;
        rd_req = 1'b1; tick(); rd_req = 1'b0;
        chk("mid_rd_grant", 32'({ens, sdram_cmd}), 32'({3'b001, rd_cmd}));
        ref_req = 1'b1; tick();
        chk("mid_rd_pend", 32'(ref_pending), 32'd1);
        #2 s_rst_n = 1'b0;
        #1;
        chk("mid_rst_outs", 32'({ens, ref_pending, tmo_err}), 32'd0);
        chk("mid_rst_bus", 32'({sdram_cmd, sdram_addr, sdram_bank}), 32'({NOPC, 12'h0, 2'b0}));
        tick();
        chk("mid_rst_hold", 32'({ens, ref_pending, sdram_cmd}), 32'({4'b0000, NOPC}));
        ref_req = 1'b0;
        s_rst_n = 1'b1;
        #1;
        chk("mid_rst_release", 32'(sdram_cmd), 32'(init_cmd));
        flag_rd_end = 1'b1; tick(); flag_rd_end = 1'b0;
        chk("mid_rst_init_stays", 32'({ens, sdram_cmd}), 32'({3'b000, init_cmd}));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
